resp_merge: RTL and testbench

Parametrised response merger for the calc2 output side. It collects result responses from NUM_SRC execution units and an invalid-op stream, and drives one registered response per cycle onto a requester port. Simultaneous execution-unit responses are resolved by fixed priority with per-source hold registers. Invalid-op responses are queued in a INV_DEPTH FIFO and emitted only in cycles with no execution response.

---
 rtl/calc2_pkg.sv | 23 ++
 rtl/inv_fifo.sv | 57 +++++
 rtl/resp_merge.sv | 155 +++++++++++++++
 tb/tb_resp_merge.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc2_pkg.sv
// calc2_pkg: response encodings, default widths and the response record
// shared by the calc2 output-side blocks.
package calc2_pkg;

  localparam int CALC2_DATA_W = 32;
  localparam int CALC2_TAG_W  = 2;

  // 2'b11 is reserved; consumers treat it as a valid response and pass it on.
  localparam logic [1:0] RESP_NONE = 2'b00;
  localparam logic [1:0] RESP_OK   = 2'b01;
  localparam logic [1:0] RESP_ERR  = 2'b10;

  typedef struct packed {
    logic [1:0]              resp;
    logic [CALC2_DATA_W-1:0] data;
    logic [CALC2_TAG_W-1:0]  tag;
  } calc2_resp_t;

  function automatic logic resp_is_valid(input logic [1:0] r);
    return r != RESP_NONE;
  endfunction

endpackage

// File: rtl/inv_fifo.sv
// inv_fifo: tag queue for invalid-op responses. State updates on the
// falling clock edge. A push on a full queue is taken only when a pop
// retires the head in the same cycle; otherwise it is reported on o_drop.
// Pushes never bypass to the head: an entry written into an empty queue
// becomes visible on the next cycle.
module inv_fifo #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 2
) (
  input  logic             c_clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [TAG_W-1:0] i_tag,
  output logic [TAG_W-1:0] o_head_tag,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_drop
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [TAG_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;

  logic w_pop;
  logic w_push;

  assign o_full     = (r_cnt == CW'(DEPTH));
  assign o_empty    = (r_cnt == '0);
  assign o_head_tag = r_mem[r_rd];

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);
  assign o_drop = i_push & ~w_push;

  // Storage needs no reset: only entries counted by r_cnt are ever read.
  always_ff @(negedge c_clk) begin
    if (w_push) r_mem[r_wr] <= i_tag;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(negedge c_clk or negedge reset) begin
    if (!reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/resp_merge.sv
// resp_merge: merges NUM_SRC execution-unit responses plus a queued
// invalid-op stream onto one registered requester port. Lowest source
// index wins; losers park in a one-deep per-source hold register.
// Invalid-op responses only go out in cycles with no execution response.
// Build option RESP_MERGE_HOLD_EN: when undefined there are no hold
// registers and every losing live response is dropped (collide_err).
// All state updates on the falling edge of c_clk; reset is async low.
module resp_merge
  import calc2_pkg::*;
#(
  parameter int DATA_W    = CALC2_DATA_W,
  parameter int TAG_W     = CALC2_TAG_W,
  parameter int NUM_SRC   = 2,
  parameter int INV_DEPTH = 4
) (
  input  logic                      c_clk,
  input  logic                      reset,
  input  logic [NUM_SRC*2-1:0]      src_resp,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
  input  logic                      invalid_op,
  input  logic [TAG_W-1:0]          invalid_op_tag,
  output logic [1:0]                req_resp,
  output logic [DATA_W-1:0]         req_data,
  output logic [TAG_W-1:0]          req_tag,
  output logic                      inv_full,
  output logic                      collide_err,
  output logic                      inv_ovf
);

  typedef struct packed {
    logic [1:0]        resp;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } rec_t;

  rec_t [NUM_SRC-1:0] w_live;
  rec_t [NUM_SRC-1:0] w_eff;
  logic [NUM_SRC-1:0] w_live_vld;
  logic [NUM_SRC-1:0] w_eff_vld;
  logic [NUM_SRC-1:0] w_win_oh;
  logic [NUM_SRC-1:0] w_drop;

  rec_t             w_win;
  logic             w_win_vld;
  logic             w_pop;
  logic             w_fifo_empty;
  logic             w_fifo_drop;
  logic [TAG_W-1:0] w_head_tag;

  rec_t r_out;
  logic r_collide;
  logic r_ovf;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign w_live[gi]     = {src_resp[2*gi +: 2],
                             src_data[gi*DATA_W +: DATA_W],
                             src_tag[gi*TAG_W +: TAG_W]};
    assign w_live_vld[gi] = resp_is_valid(src_resp[2*gi +: 2]);

`ifdef RESP_MERGE_HOLD_EN
    rec_t r_hold;
    logic r_hold_vld;

    // A held response is older than the live one, so it always goes first.
    assign w_eff_vld[gi] = r_hold_vld | w_live_vld[gi];
    assign w_eff[gi]     = r_hold_vld ? r_hold : w_live[gi];
    assign w_drop[gi]    = w_live_vld[gi] & ~w_win_oh[gi] & r_hold_vld;

    // Hold update: refill behind a winning hold, capture a losing live
    // response when the slot is free; a losing response on a busy slot is lost.
    always_ff @(negedge c_clk or negedge reset) begin
      if (!reset) begin
        r_hold_vld <= 1'b0;
        r_hold     <= '0;
      end else if (w_win_oh[gi]) begin
        if (r_hold_vld) begin
          r_hold_vld <= w_live_vld[gi];
          r_hold     <= w_live[gi];
        end
      end else if (w_live_vld[gi] && !r_hold_vld) begin
        r_hold_vld <= 1'b1;
        r_hold     <= w_live[gi];
      end
    end
`else
    assign w_eff_vld[gi] = w_live_vld[gi];
    assign w_eff[gi]     = w_live[gi];
    assign w_drop[gi]    = w_live_vld[gi] & ~w_win_oh[gi];
`endif
  end

  // Isolate the lowest set request bit: index 0 has top priority.
  assign w_win_oh  = w_eff_vld & (~w_eff_vld + NUM_SRC'(1));
  assign w_win_vld = |w_eff_vld;

  // One-hot mux of the winning record.
  always_comb begin
    w_win = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_win_oh[i]) w_win = w_eff[i];
    end
  end

  // Invalid-op queue drains only in cycles with no execution response.
  assign w_pop = ~w_win_vld & ~w_fifo_empty;

  inv_fifo #(
    .DEPTH (INV_DEPTH),
    .TAG_W (TAG_W)
  ) u_inv_fifo (
    .c_clk      (c_clk),
    .reset      (reset),
    .i_push     (invalid_op),
    .i_pop      (w_pop),
    .i_tag      (invalid_op_tag),
    .o_head_tag (w_head_tag),
    .o_full     (inv_full),
    .o_empty    (w_fifo_empty),
    .o_drop     (w_fifo_drop)
  );

  // Output register: winner, else queued invalid-op, else idle.
  always_ff @(negedge c_clk or negedge reset) begin
    if (!reset) begin
      r_out <= '0;
    end else if (w_win_vld) begin
      r_out <= w_win;
    end else if (w_pop) begin
      r_out.resp <= RESP_ERR;
      r_out.data <= '0;
      r_out.tag  <= w_head_tag;
    end else begin
      r_out <= '0;
    end
  end

  // Sticky loss flags, cleared only by reset.
  always_ff @(negedge c_clk or negedge reset) begin
    if (!reset) begin
      r_collide <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (|w_drop)     r_collide <= 1'b1;
      if (w_fifo_drop) r_ovf     <= 1'b1;
    end
  end

  assign req_resp    = r_out.resp;
  assign req_data    = r_out.data;
  assign req_tag     = r_out.tag;
  assign collide_err = r_collide;
  assign inv_ovf     = r_ovf;

endmodule

// File: tb/tb_resp_merge.sv
// tb_resp_merge: directed scenarios plus randomized traffic against a
// queue-based behavioural model. Inputs change 1 ns after each falling
// edge; outputs are sampled at that same point.
module tb_resp_merge;
  import calc2_pkg::*;

  localparam int DW = 32;
  localparam int TW = 2;
  localparam int NS = 2;
  localparam int ID = 4;
`ifdef RESP_MERGE_HOLD_EN
  localparam int HOLD_CAP = 1;
`else
  localparam int HOLD_CAP = 0;
`endif

  logic              c_clk;
  logic              reset;
  logic [NS*2-1:0]   src_resp;
  logic [NS*DW-1:0]  src_data;
  logic [NS*TW-1:0]  src_tag;
  logic              invalid_op;
  logic [TW-1:0]     invalid_op_tag;
  logic [1:0]        req_resp;
  logic [DW-1:0]     req_data;
  logic [TW-1:0]     req_tag;
  logic              inv_full;
  logic              collide_err;
  logic              inv_ovf;

  int n_checks = 0;
  int n_err    = 0;

  resp_merge #(.DATA_W(DW), .TAG_W(TW), .NUM_SRC(NS), .INV_DEPTH(ID)) dut (
    .c_clk(c_clk), .reset(reset), .src_resp(src_resp), .src_data(src_data),
    .src_tag(src_tag), .invalid_op(invalid_op), .invalid_op_tag(invalid_op_tag),
    .req_resp(req_resp), .req_data(req_data), .req_tag(req_tag),
    .inv_full(inv_full), .collide_err(collide_err), .inv_ovf(inv_ovf)
  );

  initial c_clk = 1'b1;
  always #5 c_clk = ~c_clk;

  // ---------------- behavioural model ----------------
  // Each source owns a pending list of capacity HOLD_CAP; the invalid-op
  // stream is a bounded tag queue. Output is the register value.
  calc2_resp_t m_pend [NS][$];
  logic [TW-1:0] m_fq[$];
  calc2_resp_t   m_out;
  bit            m_col;
  bit            m_ovf;

  task automatic m_reset();
    for (int i = 0; i < NS; i++) m_pend[i].delete();
    m_fq.delete();
    m_out = '0;
    m_col = 0;
    m_ovf = 0;
  endtask

  function automatic bit m_full();
    return m_fq.size() == ID;
  endfunction

  task automatic m_step();
    calc2_resp_t live [NS];
    bit          lv   [NS];
    int          win;
    win = -1;
    for (int i = 0; i < NS; i++) begin
      live[i].resp = src_resp[2*i +: 2];
      live[i].data = src_data[DW*i +: DW];
      live[i].tag  = src_tag[TW*i +: TW];
      lv[i] = live[i].resp != 2'b00;
    end
    for (int i = 0; i < NS; i++)
      if (win < 0 && (m_pend[i].size() > 0 || lv[i])) win = i;
    if (win >= 0) begin
      if (m_pend[win].size() > 0) begin
        m_out = m_pend[win].pop_front();
        if (lv[win]) m_pend[win].push_back(live[win]);
      end else begin
        m_out = live[win];
      end
    end else if (m_fq.size() > 0) begin
      m_out = '{resp: RESP_ERR, data: '0, tag: m_fq.pop_front()};
    end else begin
      m_out = '0;
    end
    for (int i = 0; i < NS; i++) begin
      if (i != win && lv[i]) begin
        if (m_pend[i].size() < HOLD_CAP) m_pend[i].push_back(live[i]);
        else m_col = 1;
      end
    end
    if (invalid_op) begin
      if (m_fq.size() < ID) m_fq.push_back(invalid_op_tag);
      else m_ovf = 1;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    src_resp = '0; src_data = '0; src_tag = '0;
    invalid_op = 1'b0; invalid_op_tag = '0;
  endtask

  task automatic set_src(input int i, input logic [1:0] r, input logic [DW-1:0] d,
                         input logic [TW-1:0] t);
    src_resp[2*i +: 2]  = r;
    src_data[DW*i +: DW] = d;
    src_tag[TW*i +: TW]  = t;
  endtask

  task automatic tick();
    m_step();
    @(negedge c_clk);
    #1;
  endtask

  // Called 1 ns after a falling edge; releases before the next one.
  task automatic do_reset();
    idle();
    #2 reset = 1'b0;
    m_reset();
    #5 reset = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    if ({req_resp, req_data, req_tag, inv_full, collide_err, inv_ovf} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got %h/%h/%h f%b c%b o%b want all 0",
               req_resp, req_data, req_tag, inv_full, collide_err, inv_ovf);
    end
    n_checks++;
  endtask

  task automatic test_single();
    idle();
    set_src(0, 2'b01, 32'h5, 2'd2);
    tick();
    if ({req_resp, req_data, req_tag} !== {2'b01, 32'h5, 2'd2}) begin
      n_err++;
      $display("FAIL single_resp got %h/%h/%h want 1/00000005/2", req_resp, req_data, req_tag);
    end
    n_checks++;
    idle();
    tick();
    if ({req_resp, req_data, req_tag} !== '0) begin
      n_err++;
      $display("FAIL single_idle got %h/%h/%h want 0/0/0", req_resp, req_data, req_tag);
    end
    n_checks++;
  endtask

  task automatic test_collision();
    logic [DW+3:0] want2;
    bit            want_col;
    idle();
    set_src(0, 2'b01, 32'hA, 2'd1);
    set_src(1, 2'b10, 32'hB, 2'd3);
    tick();
    if ({req_resp, req_data, req_tag} !== {2'b01, 32'hA, 2'd1}) begin
      n_err++;
      $display("FAIL collide_first got %h/%h/%h want 1/0000000a/1", req_resp, req_data, req_tag);
    end
    n_checks++;
    idle();
    tick();
    want2    = (HOLD_CAP > 0) ? {2'b10, 32'hB, 2'd3} : '0;
    want_col = (HOLD_CAP == 0);
    if ({req_resp, req_data, req_tag} !== want2 || collide_err !== want_col) begin
      n_err++;
      $display("FAIL collide_second got %h/%h/%h c%b want %h c%b",
               req_resp, req_data, req_tag, collide_err, want2, want_col);
    end
    n_checks++;
    do_reset();
  endtask

  task automatic test_hold_overflow();
    logic [DW+3:0] want;
    idle();
    for (int k = 0; k < 3; k++) begin
      set_src(0, 2'b01, 32'h100 + k, 2'(k));
      if (k < 2) set_src(1, 2'b01, 32'h200 + k, 2'(k));
      else       set_src(1, 2'b00, '0, '0);
      tick();
      if ({req_resp, req_data, req_tag} !== {2'b01, 32'h100 + k, 2'(k)}) begin
        n_err++;
        $display("FAIL hold_ovf_src0 k=%0d got %h/%h/%h", k, req_resp, req_data, req_tag);
      end
      n_checks++;
    end
    idle();
    tick();
    want = (HOLD_CAP > 0) ? {2'b01, 32'h200, 2'd0} : '0;
    if ({req_resp, req_data, req_tag} !== want || collide_err !== 1'b1) begin
      n_err++;
      $display("FAIL hold_ovf_drain got %h/%h/%h c%b want %h c1",
               req_resp, req_data, req_tag, collide_err, want);
    end
    n_checks++;
    tick();
    if ({req_resp, req_data, req_tag} !== '0) begin
      n_err++;
      $display("FAIL hold_ovf_dropped got %h/%h/%h want 0/0/0", req_resp, req_data, req_tag);
    end
    n_checks++;
    do_reset();
  endtask

  task automatic test_inv_queue();
    logic [TW-1:0] tags [5];
    tags = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    idle();
    for (int k = 0; k <= 5; k++) begin
      invalid_op     = (k < 5);
      invalid_op_tag = (k < 5) ? tags[k] : '0;
      tick();
      if (k == 0) begin
        if ({req_resp, req_data, req_tag} !== '0) begin
          n_err++;
          $display("FAIL inv_no_bypass got %h/%h/%h want 0/0/0", req_resp, req_data, req_tag);
        end
      end else if ({req_resp, req_data, req_tag} !== {2'b10, 32'h0, tags[k-1]} ||
                   inv_ovf !== 1'b0) begin
        n_err++;
        $display("FAIL inv_pop k=%0d got %h/%h/%h o%b want 2/0/%h o0",
                 k, req_resp, req_data, req_tag, inv_ovf, tags[k-1]);
      end
      n_checks++;
    end
    // Second pass: src0 keeps the port busy so the queue fills and overflows.
    for (int k = 0; k < 5; k++) begin
      set_src(0, 2'b01, 32'h300 + k, 2'(k));
      invalid_op     = 1'b1;
      invalid_op_tag = tags[k];
      tick();
      if (k == 3 && (inv_full !== 1'b1 || inv_ovf !== 1'b0)) begin
        n_err++;
        $display("FAIL inv_fill full=%b ovf=%b want full=1 ovf=0", inv_full, inv_ovf);
      end
      if (k == 4 && (inv_full !== 1'b1 || inv_ovf !== 1'b1)) begin
        n_err++;
        $display("FAIL inv_overflow full=%b ovf=%b want full=1 ovf=1", inv_full, inv_ovf);
      end
      if (k >= 3) n_checks++;
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      tick();
      if ({req_resp, req_data, req_tag} !== {2'b10, 32'h0, tags[k]}) begin
        n_err++;
        $display("FAIL inv_drain k=%0d got %h/%h/%h want 2/0/%h", k, req_resp, req_data, req_tag, tags[k]);
      end
      n_checks++;
    end
    tick();
    if ({req_resp, req_data, req_tag} !== '0 || inv_full !== 1'b0) begin
      n_err++;
      $display("FAIL inv_empty got %h/%h/%h full=%b want 0/0/0 full=0",
               req_resp, req_data, req_tag, inv_full);
    end
    n_checks++;
    do_reset();
  endtask

  task automatic test_reset_mid();
    idle();
    set_src(0, 2'b01, 32'h11, 2'd1);
    set_src(1, 2'b01, 32'h22, 2'd2);
    invalid_op = 1'b1; invalid_op_tag = 2'd3;
    tick();
    set_src(1, 2'b00, '0, '0);
    invalid_op_tag = 2'd1;
    tick();
    idle();
    #2 reset = 1'b0;
    m_reset();
    #1;
    if ({req_resp, req_data, req_tag, inv_full, collide_err, inv_ovf} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_async got %h/%h/%h f%b c%b o%b want all 0",
               req_resp, req_data, req_tag, inv_full, collide_err, inv_ovf);
    end
    n_checks++;
    #4 reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if ({req_resp, req_data, req_tag, inv_full, collide_err, inv_ovf} !== '0) begin
        n_err++;
        $display("FAIL reset_mid_after k=%0d got %h/%h/%h f%b c%b o%b want all 0",
                 k, req_resp, req_data, req_tag, inv_full, collide_err, inv_ovf);
      end
      n_checks++;
    end
  endtask

  task automatic test_ptr_wrap();
    logic [TW-1:0] t;
    idle();
    for (int k = 0; k < 10; k++) begin
      t = TW'($urandom_range(0, 3));
      invalid_op = 1'b1; invalid_op_tag = t;
      tick();
      invalid_op = 1'b0;
      tick();
      if ({req_resp, req_data, req_tag} !== {2'b10, 32'h0, t} || inv_full !== 1'b0) begin
        n_err++;
        $display("FAIL ptr_wrap k=%0d got %h/%h/%h full=%b want 2/0/%h full=0",
                 k, req_resp, req_data, req_tag, inv_full, t);
      end
      n_checks++;
      if (k % 3 == 2) tick();
    end
  endtask

  task automatic test_back_to_back();
    idle();
    for (int k = 0; k < 4; k++) begin
      set_src(1, 2'b11, 32'h400 + k, 2'(k));
      tick();
      if ({req_resp, req_data, req_tag} !== {2'b11, 32'h400 + k, 2'(k)}) begin
        n_err++;
        $display("FAIL b2b_src1 k=%0d got %h/%h/%h", k, req_resp, req_data, req_tag);
      end
      n_checks++;
    end
    idle();
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NS; i++) begin
        if ($urandom_range(0, 1) == 0) set_src(i, 2'b00, '0, '0);
        else set_src(i, 2'($urandom_range(1, 3)), $urandom, TW'($urandom_range(0, 3)));
      end
      invalid_op     = ($urandom_range(0, 9) < 3);
      invalid_op_tag = TW'($urandom_range(0, 3));
      tick();
      if ({req_resp, req_data, req_tag} !== m_out) begin
        n_err++;
        $display("FAIL rand_out c=%0d got %h/%h/%h want %h/%h/%h",
                 c, req_resp, req_data, req_tag, m_out.resp, m_out.data, m_out.tag);
      end
      n_checks++;
      if ({inv_full, collide_err, inv_ovf} !== {m_full(), m_col, m_ovf}) begin
        n_err++;
        $display("FAIL rand_flags c=%0d got f%b c%b o%b want f%b c%b o%b",
                 c, inv_full, collide_err, inv_ovf, m_full(), m_col, m_ovf);
      end
      n_checks++;
      if (c == 200) do_reset();
    end
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    m_reset();
    #2 reset = 1'b0;
    #1 test_reset();
    #9 reset = 1'b1;
    test_single();
    test_collision();
    test_hold_overflow();
    test_inv_queue();
    test_reset_mid();
    test_ptr_wrap();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
